// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter (data over inst) with an in-order owner FIFO that routes data_ok back.
// Latency: 0 cycles; backpressure: req withheld while the owner FIFO is full, lock holds the grant until addr_ok.
module sram_like_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             lock_q, lock_d;
  logic             lock_owner_q, lock_owner_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;

  logic sel_data, sel_req, fifo_full, fifo_empty, head, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    fifo_full  = (count_q == CW'(DEPTH));
    fifo_empty = (count_q == '0);
    head       = fifo_q[rd_ptr_q];
    // A pending, not-yet-accepted request keeps its master so the slave sees stable fields.
    sel_data   = lock_q ? lock_owner_q : data_req;
    sel_req    = sel_data ? data_req : inst_req;
    req        = sel_req & ~fifo_full & resetn;

    wr    = 1'b0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    if (req) begin
      if (sel_data) begin
        wr    = data_wr;
        size  = data_size;
        addr  = data_addr;
        wdata = data_wdata;
      end else begin
        wr    = inst_wr;
        size  = inst_size;
        addr  = inst_addr;
        wdata = inst_wdata;
      end
    end

    inst_addr_ok = addr_ok & req & ~sel_data;
    data_addr_ok = addr_ok & req & sel_data;

    push = req & addr_ok;
    // Responses with nothing outstanding (including same-cycle addr/data) are dropped.
    pop  = data_ok & ~fifo_empty & resetn;

    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    inst_rdata   = rdata;
    data_rdata   = rdata;
  end

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_d       = fifo_q;

    if (push) begin
      lock_d = 1'b0;
    end else if (req) begin
      lock_d       = 1'b1;
      lock_owner_d = sel_data;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = sel_data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fifo_q       <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the CPU's sram-like memory interface. It shares a single sram-like slave port between the instruction-fetch master and the data master, with the data master carrying loads and stores from the EX/MEM stages. It sits between the core's `inst_sram_*` / `data_sram_*` ports and the downstream bridge. Each request is forwarded with zero added latency, and every `data_ok` response is routed back to the master that issued it, in order, through an owner FIFO.

## Interface
- `DEPTH`, default 2: maximum number of outstanding (address accepted, data not yet returned) transactions. Must be a power of 2 and at least 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous reset, active-low.
- `inst_req`, `inst_wr`  in  1,1  inst master request and write flag.
- `inst_size`  in  2  inst master size (0 = byte, 1 = half, 2 = word).
- `inst_addr`, `inst_wdata`  in  32,32  inst master address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1,1  inst master handshakes.
- `inst_rdata`  out  32  inst master read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`  in  1,1,2,32,32  data master request fields, same meaning as the inst master.
- `data_addr_ok`, `data_data_ok`  out  1,1  data master handshakes.
- `data_rdata`  out  32  data master read data.
- `req`, `wr`  out  1,1  slave request and write flag.
- `size`  out  2  slave size.
- `addr`, `wdata`  out  32,32  slave address and write data.
- `addr_ok`, `data_ok`  in  1,1  slave handshakes.
- `rdata`  in  32  slave read data.

## Operation
- **Grant selection**
  - When the arbiter is not locked, data has priority: `sel_data = data_req`; otherwise inst is selected.
  - When locked, selection is `lock_owner`.
- **Slave request**
  - `req = sel_req & ~fifo_full & resetn`.
  - `wr`, `size`, `addr`, `wdata` are muxed from the selected master.
  - When `req` = 0, all slave request fields are 0.
- **Address handshake**
  - `<sel>_addr_ok = addr_ok & req & sel`.
  - The unselected master's `addr_ok` is 0.
- **Lock**
  - Set when `req` = 1 and `addr_ok` = 0; `lock_owner` records the selected master.
  - Cleared on the cycle `req & addr_ok`.
  - While locked, a data request arriving behind a pending inst request does not pre-empt it. Slave request fields must stay stable until accepted.
- **Owner FIFO**
  - DEPTH entries, 1 bit each (1 = data master).
  - Read/write pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus a count of `$clog2(DEPTH)+1` bits.
  - Push the owner bit on `req & addr_ok`. Pop on `data_ok & ~fifo_empty`.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - `fifo_full` (count == DEPTH) blocks new slave requests. A pop in the same cycle does not unblock the request (no bypass).
- **Response routing**
  - `inst_data_ok = data_ok & ~fifo_empty & ~head`.
  - `data_data_ok = data_ok & ~fifo_empty & head`.
  - `inst_rdata = data_rdata = rdata`.
  - A `data_ok` with an empty FIFO (spurious) is dropped: no master sees it and the state is unchanged.
- **Same-cycle address and data**
  - `data_ok` in the same cycle as `addr_ok` for a new request, with the FIFO empty, is treated as spurious.
  - The slave must return data no earlier than the cycle after `addr_ok`.
- **Reset**
  - While `resetn` = 0 at a clock edge: pointers and count go to 0, lock is cleared, `lock_owner` goes to 0.
  - Any response arriving after reset for pre-reset requests is dropped as spurious.

## Timing
- The arbiter adds 0 cycles. Address and data handshakes are combinational pass-through gated by arbiter state.
- Reset values: `req`, `addr_ok`s and `data_ok`s are 0, FIFO is empty, unlocked. While `resetn` = 0, `req` = 0 regardless of master inputs.
- Throughput: one accepted address per cycle while the FIFO is not full. With DEPTH = 2, at most 2 transactions are outstanding.
- Responses are returned strictly in address-acceptance order. No reordering between masters.
- The lock holds for N+1 cycles for a slave that withholds `addr_ok` for N cycles.

## Test plan
- **Priority:** `inst_req` = `data_req` = 1, `addr_ok` = 1 in the same cycle, `data_addr` = 0x1000 → `addr` = 0x1000, `data_addr_ok` = 1, `inst_addr_ok` = 0. The next cycle `data_req` = 0 → inst address issued.
- **Lock:** `inst_req` = 1 with `addr_ok` = 0 for 3 cycles, then `data_req` rises at cycle 1 → `addr` stays at `inst_addr` through cycle 3. On `addr_ok` at cycle 3, `inst_addr_ok` = 1. Data is granted at cycle 4.
- **Routing:** accept inst read (0x2000) then data read (0x3000). Slave returns `data_ok` with `rdata` 0xAAAA0000 then 0xBBBB0000 → `inst_data_ok` pulses with 0xAAAA0000, then `data_data_ok` pulses with 0xBBBB0000.
- **Full:** DEPTH = 2, two accepted and no `data_ok` → `req` = 0 on a third request. A `data_ok` in cycle N leaves `req` = 0 in N, and `req` = 1 in N+1.
- **Simultaneous push/pop and wrap:** 6 back-to-back alternating inst/data transactions with `data_ok` every cycle after the first → count stays 1, pointers wrap, and all 6 `data_ok`s route to the correct master.
- **Reset mid-operation:** 2 outstanding, then `resetn` = 0 for 1 cycle, then `data_ok` = 1 → no master `data_ok`, FIFO is empty, `req` = 0 during reset.
